// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 16:1 mux.
// Registered one-hot grant, hold limit while others wait.
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  select,
    output logic        busy,
    output logic        preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit LIMITED = (HOLD_MAX != 0);
    localparam logic [CW-1:0] HOLD_LAST =
        (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);

    state_t          state;
    logic [3:0]      ptr;
    logic [CW-1:0]   hold_cnt;

    logic [31:0]     dbl;
    logic [15:0]     rot;
    logic [3:0]      off;
    logic [3:0]      pick;
    logic            found;
    logic            others;
    logic            owner_req;
    logic            hold_done;

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req};
        rot   = 16'(dbl >> ptr);
        off   = '0;
        for (int k = 15; k >= 0; k--) begin
            if (rot[k]) off = 4'(k);
        end
        found = |req;
        pick  = ptr + off;
    end

    // Owner status used by the release and preemption decisions.
    always_comb begin
        others    = |(req & ~grant);
        owner_req = req[select];
        hold_done = LIMITED && (hold_cnt == HOLD_LAST);
    end

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            select   <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= 16'h1 << pick;
                        select   <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= select + 4'd1;
                    end else if (hold_done && others) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        ptr     <= select + 4'd1;
                        preempt <= 1'b1;
                    end else if (LIMITED && hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: limited (8) and unlimited (0) hold
// instances fed the same requests, checked against a cycle model.
module tb_mux_rr_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] req;

    logic [15:0] grant_l, grant_u;
    logic [3:0]  select_l, select_u;
    logic        busy_l, busy_u;
    logic        preempt_l, preempt_u;

    int n_cmp = 0;
    int n_err = 0;

    // model state: index 0 = HOLD_MAX 8, index 1 = HOLD_MAX 0
    int m_own[2];
    int m_ptr[2];
    int m_held[2];
    int m_sel[2];
    bit m_pre[2];
    int hold_of[2] = '{8, 0};

    always #5 clock = ~clock;

    mux_rr_arbiter #(.HOLD_MAX(8), .CW(4)) u_lim (
        .clock(clock), .reset(reset), .req(req),
        .grant(grant_l), .select(select_l),
        .busy(busy_l), .preempt(preempt_l)
    );

    mux_rr_arbiter #(.HOLD_MAX(0), .CW(4)) u_unl (
        .clock(clock), .reset(reset), .req(req),
        .grant(grant_u), .select(select_u),
        .busy(busy_u), .preempt(preempt_u)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_ptr[i] = 0; m_held[i] = 0;
            m_sel[i] = 0;  m_pre[i] = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules, in integer terms.
    task automatic model_edge(int i);
        logic [15:0] mine;
        m_pre[i] = 1'b0;
        if (m_own[i] < 0) begin
            if (req != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    int j;
                    j = (m_ptr[i] + k) % 16;
                    if (m_own[i] < 0 && req[j]) m_own[i] = j;
                end
                m_sel[i]  = m_own[i];
                m_held[i] = 1;
            end
        end else begin
            mine = 16'h1 << m_own[i];
            if (!req[m_own[i]]) begin
                m_ptr[i] = (m_own[i] + 1) % 16;
                m_own[i] = -1;
            end else if (hold_of[i] != 0 && m_held[i] >= hold_of[i]
                         && (req & ~mine) != 16'h0) begin
                m_ptr[i] = (m_own[i] + 1) % 16;
                m_own[i] = -1;
                m_pre[i] = 1'b1;
            end else begin
                m_held[i]++;
            end
        end
    endtask

    function automatic logic [15:0] exp_grant(int i);
        return (m_own[i] < 0) ? 16'h0 : (16'h1 << m_own[i]);
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("lim.grant",   grant_l,          exp_grant(0));
        check("lim.select",  16'(select_l),    16'(m_sel[0]));
        check("lim.busy",    16'(busy_l),      16'(m_own[0] >= 0));
        check("lim.preempt", 16'(preempt_l),   16'(m_pre[0]));
        check("unl.grant",   grant_u,          exp_grant(1));
        check("unl.select",  16'(select_u),    16'(m_sel[1]));
        check("unl.busy",    16'(busy_u),      16'(m_own[1] >= 0));
        check("unl.preempt", 16'(preempt_u),   16'(m_pre[1]));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1 check_all();
    endtask

    // Asynchronous reset between edges, released on the negedge.
    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    int pre_cnt;
    int lim_bit0;

    initial begin
        reset = 1'b1;
        req   = 16'h0;
        model_reset();
        #2 check_all();
        @(negedge clock);
        reset = 1'b0;

        // reset mid-grant, then a fresh grant to requester 4
        req = 16'h0020;
        tick();
        tick();
        async_reset();
        check("rst.grant", grant_l, 16'h0000);
        req = 16'h0010;
        tick();
        check("rst.grant4", grant_l, 16'h0010);
        check("rst.sel4", 16'(select_l), 16'd4);
        req = 16'h0;
        tick();

        // priority wrap from ptr 0
        async_reset();
        req = 16'h8001;
        tick();
        check("wrap.first", grant_l, 16'h0001);
        req = 16'h8000;
        tick();
        check("wrap.idle", grant_l, 16'h0000);
        tick();
        check("wrap.g15", grant_l, 16'h8000);
        check("wrap.s15", 16'(select_l), 16'd15);
        req = 16'h0;
        tick();
        tick();
        req = 16'h0003;
        tick();
        check("wrap.ptr0", grant_l, 16'h0001);
        req = 16'h0;
        tick();

        // round-robin: every owner drops one cycle after its grant
        async_reset();
        req = 16'hFFFF;
        for (int n = 0; n < 17; n++) begin
            tick();
            check("rr.order", grant_l, 16'h1 << (n % 16));
            req = 16'hFFFF & ~grant_l;
            tick();
            check("rr.gap", grant_l, 16'h0000);
            req = 16'hFFFF;
        end
        req = 16'h0;
        tick();

        // preemption vs unlimited hold with two constant requesters
        async_reset();
        req = 16'h0003;
        pre_cnt  = 0;
        lim_bit0 = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (preempt_u) pre_cnt++;
            if (n < 10 && grant_l == 16'h0001) lim_bit0++;
        end
        check("unl.held", grant_u, 16'h0001);
        check("unl.nopre", 16'(pre_cnt), 16'd0);
        check("lim.len8", 16'(lim_bit0), 16'd8);
        req = 16'h0;
        tick();

        // saturation with a lone owner, then a competitor arrives
        async_reset();
        req = 16'h0004;
        for (int n = 0; n < 20; n++) tick();
        check("sat.hold", grant_l, 16'h0004);
        req = 16'h0204;
        tick();
        check("sat.pre", 16'(preempt_l), 16'd1);
        tick();
        check("sat.g9", grant_l, 16'h0200);
        req = 16'h0;
        tick();

        // random traffic with slowly toggling requests
        async_reset();
        for (int n = 0; n < 400; n++) begin
            req = req ^ 16'($urandom & $urandom & $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
